// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Parametrised raster timing generator. Walks a pixel/line
//                raster (active, front porch, sync, back porch) one pixel per
//                qualified pixel strobe. Decodes sync, data-enable and pixel
//                coordinates, and emits line/animate/frame-end strobes plus a
//                free-running completed-frame counter.
//  Ports       :
//    i_clk        base clock
//    i_rst        synchronous active-high reset
//    i_pix_stb    pixel-clock strobe, one raster advance per asserted cycle
//    i_paused     freezes counters and suppresses strobes
//    o_hs/o_vs    horizontal/vertical sync, asserted level per HS_POL/VS_POL
//    o_de         high in the active region; o_blanking is its complement
//    o_x/o_y      active pixel column/row (held at edge values in blanking)
//    o_line_end   one-cycle pulse on the last pixel of each line
//    o_animate    one-cycle pulse on the last pixel of line ANIM_LINE
//    o_screenend  one-cycle pulse on the last pixel of the frame
//    o_frame      completed-frame count (wraps modulo 2^FRAME_W)
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int ANIM_LINE = V_ACTIVE - 1,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int FRAME_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  input  logic               i_paused,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_de,
  output logic               o_blanking,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic               o_line_end,
  output logic               o_animate,
  output logic               o_screenend,
  output logic [FRAME_W-1:0] o_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);

  // Every boundary below is strictly less than its TOTAL (each porch/sync is
  // at least one), so all of them fit in the counter width without wrapping.
  localparam logic [HC_W-1:0] c_H_ACT    = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] c_HS_BEG   = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] c_HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HC_W-1:0] c_H_LAST   = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] c_V_ACT    = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] c_VS_BEG   = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] c_VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VC_W-1:0] c_V_LAST   = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] c_V_ANIM   = VC_W'(ANIM_LINE);
  localparam logic [Y_W-1:0]  c_Y_LAST   = Y_W'(V_ACTIVE - 1);
  localparam logic            c_HS_ON    = (HS_POL != 0);
  localparam logic            c_VS_ON    = (VS_POL != 0);

  // Reject malformed modes at elaboration rather than producing a raster
  // with zero-length regions or an unreachable animate line.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      ANIM_LINE < 0 || ANIM_LINE >= V_TOTAL) begin : g_bad_params
    $error("video_timing_gen: illegal timing parameters");
  end

  logic [HC_W-1:0]    r_h;
  logic [VC_W-1:0]    r_v;
  logic [FRAME_W-1:0] r_frame;

  logic w_adv;
  logic w_h_last;
  logic w_v_last;
  logic w_h_act;
  logic w_v_act;

  assign w_adv    = i_pix_stb & ~i_paused;
  assign w_h_last = (r_h == c_H_LAST);
  assign w_v_last = (r_v == c_V_LAST);
  assign w_h_act  = (r_h < c_H_ACT);
  assign w_v_act  = (r_v < c_V_ACT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h     <= '0;
      r_v     <= '0;
      r_frame <= '0;
    end else if (w_adv) begin
      if (w_h_last) begin
        r_h <= '0;
        if (w_v_last) begin
          r_v     <= '0;
          r_frame <= r_frame + FRAME_W'(1);
        end else begin
          r_v <= r_v + VC_W'(1);
        end
      end else begin
        r_h <= r_h + HC_W'(1);
      end
    end
  end

  // Level outputs decode the registered counters directly.
  assign o_hs       = ((r_h >= c_HS_BEG) && (r_h < c_HS_END)) ? c_HS_ON : ~c_HS_ON;
  assign o_vs       = ((r_v >= c_VS_BEG) && (r_v < c_VS_END)) ? c_VS_ON : ~c_VS_ON;
  assign o_de       = w_h_act & w_v_act;
  assign o_blanking = ~o_de;
  // Coordinates are truncated or zero-extended to the port width.
  assign o_x        = w_h_act ? X_W'(r_h) : '0;
  assign o_y        = w_v_act ? Y_W'(r_v) : c_Y_LAST;

  // Strobes are gated by the advance so a held pixel strobe still yields a
  // single-cycle pulse per event.
  assign o_line_end  = w_adv & w_h_last;
  assign o_animate   = o_line_end & (r_v == c_V_ANIM);
  assign o_screenend = o_line_end & w_v_last;
  assign o_frame     = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Self-checking bench for video_timing_gen. Three instances
//                (default 640x480, a small mode with narrow ports, and the
//                4/1/2/1 x 3/1/1/1 mode) share one stimulus stream. A raster
//                model derives every expected output from the number of
//                qualified strobes since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, an, xw, yw, fw;
  } mode_t;

  function automatic mode_t mode(input int k);
    mode_t m;
    case (k)
      0:       m = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 479, 10, 9, 16};
      1:       m = '{10, 2, 3, 2, 6, 1, 2, 1, 0, 1, 3, 3, 4, 3};
      default: m = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 0, 0, 10, 9, 2};
    endcase
    return m;
  endfunction

  logic clk = 1'b0;
  logic rst, stb, paused;
  always #5 clk = ~clk;

  // instance 0: defaults
  logic hs0, vs0, de0, bl0, le0, an0, se0;
  logic [9:0] x0; logic [8:0] y0; logic [15:0] fr0;
  // instance 1: small mode, truncated x
  logic hs1, vs1, de1, bl1, le1, an1, se1;
  logic [2:0] x1; logic [3:0] y1; logic [2:0] fr1;
  // instance 2: 8x6 mode
  logic hs2, vs2, de2, bl2, le2, an2, se2;
  logic [9:0] x2; logic [8:0] y2; logic [1:0] fr2;

  video_timing_gen dut0 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_paused(paused),
    .o_hs(hs0), .o_vs(vs0), .o_de(de0), .o_blanking(bl0), .o_x(x0), .o_y(y0),
    .o_line_end(le0), .o_animate(an0), .o_screenend(se0), .o_frame(fr0));

  video_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(1), .ANIM_LINE(3), .X_W(3), .Y_W(4), .FRAME_W(3)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_paused(paused),
    .o_hs(hs1), .o_vs(vs1), .o_de(de1), .o_blanking(bl1), .o_x(x1), .o_y(y1),
    .o_line_end(le1), .o_animate(an1), .o_screenend(se1), .o_frame(fr1));

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(0), .ANIM_LINE(0), .FRAME_W(2)
  ) dut2 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_paused(paused),
    .o_hs(hs2), .o_vs(vs2), .o_de(de2), .o_blanking(bl2), .o_x(x2), .o_y(y2),
    .o_line_end(le2), .o_animate(an2), .o_screenend(se2), .o_frame(fr2));

  // Packed view: {frame[63:48], y[47:32], x[31:16], pad, hs,vs,de,bl,le,an,se}
  logic [63:0] act0, act1, act2;
  assign act0 = {16'(fr0), 16'(y0), 16'(x0), 9'd0, hs0, vs0, de0, bl0, le0, an0, se0};
  assign act1 = {16'(fr1), 16'(y1), 16'(x1), 9'd0, hs1, vs1, de1, bl1, le1, an1, se1};
  assign act2 = {16'(fr2), 16'(y2), 16'(x2), 9'd0, hs2, vs2, de2, bl2, le2, an2, se2};

  function automatic logic [63:0] actual(input int k);
    case (k)
      0:       return act0;
      1:       return act1;
      default: return act2;
    endcase
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, a, e);
    end
  endtask

  // Raster model: position is simply the count of qualified strobes since
  // reset, unfolded into pixel, line and frame with div/mod.
  function automatic logic [63:0] expect_out(input int k, input longint nn, input logic adv);
    mode_t  m;
    longint ht, vt, h, v, fr, x, y;
    logic   hs, vs, de, le, an, se;
    m  = mode(k);
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    h  = nn % ht;
    v  = (nn / ht) % vt;
    fr = (nn / (ht * vt)) % (longint'(1) << m.fw);
    hs = (h >= m.ha + m.hf && h < m.ha + m.hf + m.hs) ? (m.hp != 0) : (m.hp == 0);
    vs = (v >= m.va + m.vf && v < m.va + m.vf + m.vs) ? (m.vp != 0) : (m.vp == 0);
    de = (h < m.ha) && (v < m.va);
    x  = (h < m.ha) ? (h % (longint'(1) << m.xw)) : 0;
    y  = ((v < m.va) ? v : m.va - 1) % (longint'(1) << m.yw);
    le = adv && (h == ht - 1);
    an = le && (v == m.an);
    se = le && (v == vt - 1);
    return {16'(fr), 16'(y), 16'(x), 9'd0, hs, vs, de, !de, le, an, se};
  endfunction

  longint n      = 0;
  bit     mvalid = 1'b0;

  // Compare every instance on every falling edge, then step the model with
  // the inputs the next rising edge will sample.
  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < 3; k++) begin
        logic [63:0] a, e;
        a = actual(k);
        e = expect_out(k, n, stb & ~paused);
        chk($sformatf("m%0d.levels", k),  64'(a[6:3]),   64'(e[6:3]));
        chk($sformatf("m%0d.strobes", k), 64'(a[2:0]),   64'(e[2:0]));
        chk($sformatf("m%0d.x", k),       64'(a[31:16]), 64'(e[31:16]));
        chk($sformatf("m%0d.y", k),       64'(a[47:32]), 64'(e[47:32]));
        chk($sformatf("m%0d.frame", k),   64'(a[63:48]), 64'(e[63:48]));
      end
    end
    if (rst) begin
      n      = 0;
      mvalid = 1'b1;
    end else if (stb && !paused) begin
      n = n + 1;
    end
  end

  initial begin
    rst = 1'b1; stb = 1'b0; paused = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; stb = 1'b1;

    // Continuous strobe: cycle c after reset sits at raster position c.
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      case (c)
        0: begin
          chk("lit.d0.de0",  64'(act0[4]), 64'd1);
          chk("lit.d0.hs0",  64'(act0[6]), 64'd1);
          chk("lit.d0.x0",   64'(act0[31:16]), 64'd0);
        end
        639: chk("lit.d0.x639", 64'(act0[31:16]), 64'd639);
        640: chk("lit.d0.de640", 64'(act0[4]), 64'd0);
        655: chk("lit.d0.hs655", 64'(act0[6]), 64'd1);
        656: chk("lit.d0.hs656", 64'(act0[6]), 64'd0);
        751: chk("lit.d0.hs751", 64'(act0[6]), 64'd0);
        752: chk("lit.d0.hs752", 64'(act0[6]), 64'd1);
        798: chk("lit.d0.le798", 64'(act0[2]), 64'd0);
        799: chk("lit.d0.le799", 64'(act0[2]), 64'd1);
        800: chk("lit.d0.y800",  64'(act0[47:32]), 64'd1);
        default: ;
      endcase
      case (c)
        4:   chk("lit.m2.hs4",  64'(act2[6]), 64'd0);
        5:   chk("lit.m2.hs5",  64'(act2[6]), 64'd1);
        7:   chk("lit.m2.an7",  64'(act2[1]), 64'd1);
        15:  chk("lit.m2.an15", 64'(act2[1]), 64'd0);
        31:  chk("lit.m2.vs31", 64'(act2[5]), 64'd1);
        32:  chk("lit.m2.vs32", 64'(act2[5]), 64'd0);
        33:  chk("lit.m2.y33",  64'(act2[47:32]), 64'd2);
        47:  chk("lit.m2.se47", 64'(act2[0]), 64'd1);
        48:  chk("lit.m2.fr48", 64'(act2[63:48]), 64'd1);
        144: chk("lit.m2.fr144", 64'(act2[63:48]), 64'd3);
        192: chk("lit.m2.fr192", 64'(act2[63:48]), 64'd0);
        default: ;
      endcase
    end

    // Mid-line reset with a simultaneous strobe.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("lit.rst.x0",  64'(act0[31:16]), 64'd0);
    chk("lit.rst.hs0", 64'(act0[6]), 64'd1);
    chk("lit.rst.de0", 64'(act0[4]), 64'd1);
    chk("lit.rst.fr2", 64'(act2[63:48]), 64'd0);

    // Pause at pixel 100 for 50 cycles.
    repeat (100) @(posedge clk);
    #1 paused = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("lit.pause.x", 64'(act0[31:16]), 64'd100);
      chk("lit.pause.le", 64'(act0[2]), 64'd0);
    end
    @(posedge clk); #1 paused = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("lit.resume.x", 64'(act0[31:16]), 64'd101);

    // Strobe on every fourth cycle.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1 stb = (i % 4 == 0);
    end

    // Randomised strobe, pause and occasional reset.
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk);
      #1;
      stb    = ($urandom % 3) != 0;
      paused = ($urandom % 8) == 0;
      rst    = ($urandom % 3000) == 0;
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
